// File: rtl/stream_reduce.sv
// stream_reduce: frame-based bitwise reduction engine.
// Folds each valid/ready frame of WIDTH-bit words with OR/AND/XOR/XNOR (mode
// latched on the first word) and presents the folded word, its 1-bit reduction
// and the saturating word count until the result is consumed.
// Optional feature macro: STREAM_REDUCE_OVF_EN (force-close a frame at MAX_LEN
// words and flag it on out_ovf).
module stream_reduce #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 16,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_bit,
  output logic [CW-1:0]    out_count
`ifdef STREAM_REDUCE_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  // Combine the running word with a new one under the latched mode.
  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [1:0]       m);
    case (m)
      2'b00:   fold = a | b;
      2'b01:   fold = a & b;
      2'b10:   fold = a ^ b;
      default: fold = ~(a ^ b);
    endcase
  endfunction

  // Handshake flags come straight from registered state (plus reset gating).
  assign in_ready  = !rst && (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;

  // Next-state: frame start, fold, count saturation and result release.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          cnt_d   = CW'(1);
          mode_d  = mode;
          state_d = in_last ? S_HOLD : S_ACCUM;
`ifdef STREAM_REDUCE_OVF_EN
          // A single-word budget with no last marker still closes the frame.
          if (!in_last && cnt_d == MAX_CNT) begin
            state_d = S_HOLD;
            ovf_d   = 1'b1;
          end
`endif
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d   = fold(acc_q, in_data, mode_q);
          cnt_d   = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CW'(1);
          state_d = in_last ? S_HOLD : S_ACCUM;
`ifdef STREAM_REDUCE_OVF_EN
          // Budget exhausted without last: close now, remaining words start a new frame.
          if (!in_last && cnt_d == MAX_CNT) begin
            state_d = S_HOLD;
            ovf_d   = 1'b1;
          end
`endif
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end

  // Single-bit reduction of the folded word, using the frame's latched mode.
  always_comb begin
    case (mode_q)
      2'b00:   out_bit = |acc_q;
      2'b01:   out_bit = &acc_q;
      2'b10:   out_bit = ^acc_q;
      default: out_bit = ~^acc_q;
    endcase
  end

  assign out_word  = acc_q;
  assign out_count = cnt_q;
`ifdef STREAM_REDUCE_OVF_EN
  assign out_ovf   = ovf_q;
`else
  // Overflow tracking is inert without the feature.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
